// File: rtl/rand_operand_builder.sv
// Collects NUM_WORDS successive LFSR words into one OP_W-bit operand, applies the
// optional MSB/LSB forcing and retries until the candidate is below the latched limit.
`timescale 1ns/1ps
module rand_operand_builder #(
  parameter int WORD_W    = 16,
  parameter int NUM_WORDS = 4,
  parameter int FORCE_MSB = 1,
  parameter int FORCE_ODD = 1,
  parameter int MAX_RETRY = 8,
  localparam int OP_W  = WORD_W * NUM_WORDS,
  localparam int CNT_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              start_i,
  input  logic [OP_W-1:0]   limit_i,
  input  logic [WORD_W-1:0] lfsr_data_i,
  output logic              lfsr_start_o,
  output logic              lfsr_enable_o,
  output logic [OP_W-1:0]   rand_o,
  output logic              done_o,
  output logic              fail_o,
  output logic              busy_o
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] REQ   = 3'd1;
  localparam logic [2:0] CAP   = 3'd2;
  localparam logic [2:0] CHECK = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(NUM_WORDS - 1);
  localparam logic [7:0]       RETRY_MAX = 8'(MAX_RETRY);

  logic [2:0]        state;
  logic [CNT_W-1:0]  word_cnt;
  logic [7:0]        retry_cnt;
  logic [7:0]        retry_next;
  logic              fail_flag;
  logic [OP_W-1:0]   limit_reg;
  logic [OP_W-1:0]   cand;
  logic [OP_W-1:0]   forced;
  logic              accept;

  function automatic logic [OP_W-1:0] apply_force(input logic [OP_W-1:0] c);
    logic [OP_W-1:0] r;
    r = c;
    if (FORCE_MSB != 0) r[OP_W-1] = 1'b1;
    if (FORCE_ODD != 0) r[0] = 1'b1;
    return r;
  endfunction

  assign forced     = apply_force(cand);
  assign accept     = (limit_reg == '0) || (forced < limit_reg);
  assign retry_next = retry_cnt + 8'd1;

  assign lfsr_enable_o = (state == REQ);
  assign lfsr_start_o  = (state == REQ) || (state == CAP) || (state == CHECK);
  assign done_o        = (state == DONE);
  assign fail_o        = (state == DONE) && fail_flag;
  assign busy_o        = (state != IDLE);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state     <= IDLE;
      word_cnt  <= '0;
      retry_cnt <= '0;
      fail_flag <= 1'b0;
      limit_reg <= '0;
      rand_o    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            limit_reg <= limit_i;
            word_cnt  <= '0;
            retry_cnt <= '0;
            state     <= REQ;
          end
        end
        REQ: state <= CAP;
        CAP: begin
          if (word_cnt == LAST_WORD) begin
            state <= CHECK;
          end else begin
            word_cnt <= word_cnt + CNT_W'(1);
            state    <= REQ;
          end
        end
        CHECK: begin
          if (accept) begin
            rand_o    <= forced;
            fail_flag <= 1'b0;
            state     <= DONE;
          end else if (retry_next == RETRY_MAX) begin
            retry_cnt <= retry_next;
            fail_flag <= 1'b1;
            state     <= DONE;
          end else begin
            // Rejected: rebuild the whole candidate from fresh words
            retry_cnt <= retry_next;
            word_cnt  <= '0;
            state     <= REQ;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Candidate is pure data: every word is rewritten before it is ever checked
  always_ff @(posedge Clk) begin
    if (state == CAP) begin
      for (int i = 0; i < NUM_WORDS; i++) begin
        if (word_cnt == CNT_W'(i)) cand[i*WORD_W +: WORD_W] <= lfsr_data_i;
      end
    end
  end

endmodule

// File: tb/tb_rand_operand_builder.sv
// Bench for rand_operand_builder: queue-fed word stubs, vector table with a result
// scoreboard, plus hand sequences for enable pattern, mid-operation reset and LFSR source.
`timescale 1ns/1ps
module tb_rand_operand_builder;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        start_a = 1'b0, start_b = 1'b0;
  logic [63:0] limit_a = '0, limit_b = '0;
  logic [15:0] data_a = '0, data_b = '0;
  logic        lst_a, en_a, done_a, fail_a, busy_a;
  logic        lst_b, en_b, done_b, fail_b, busy_b;
  logic [63:0] rand_a, rand_b;

  rand_operand_builder dut_a (
    .Clk(Clk), .Reset(Reset), .start_i(start_a), .limit_i(limit_a), .lfsr_data_i(data_a),
    .lfsr_start_o(lst_a), .lfsr_enable_o(en_a), .rand_o(rand_a), .done_o(done_a),
    .fail_o(fail_a), .busy_o(busy_a));

  rand_operand_builder #(.FORCE_MSB(0), .FORCE_ODD(0)) dut_b (
    .Clk(Clk), .Reset(Reset), .start_i(start_b), .limit_i(limit_b), .lfsr_data_i(data_b),
    .lfsr_start_o(lst_b), .lfsr_enable_o(en_b), .rand_o(rand_b), .done_o(done_b),
    .fail_o(fail_b), .busy_o(busy_b));

  always #5 Clk = ~Clk;

  // Generator stubs: a new word is registered on every edge where Enable is high
  logic [15:0] wq_a[$], wq_b[$], issued[$];
  bit          gen_mode = 1'b0;
  logic [15:0] lfsr = 16'hACE1;

  always @(posedge Clk) begin
    if (en_a) begin
      if (gen_mode) begin
        data_a <= lfsr;
        issued.push_back(lfsr);
      end else if (wq_a.size() > 0) begin
        data_a <= wq_a.pop_front();
      end
    end
    if (en_b && wq_b.size() > 0) data_b <= wq_b.pop_front();
    if (gen_mode && lst_a) lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  end

  typedef struct {
    logic [63:0]  limit;
    logic [127:0] words;
    int           nw;
    bit           from_gen;
    logic [63:0]  exp_rand;
    bit           exp_fail;
    int           exp_edge;
  } vec_t;

  typedef struct {
    logic [63:0] rnd;
    bit          fail;
    int          edge_n;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [63:0] limit, input logic [127:0] words, input int nw,
                              input logic [63:0] exp_rand, input bit exp_fail, input int exp_edge);
    vec_t v;
    v.limit = limit; v.words = words; v.nw = nw; v.from_gen = 1'b0;
    v.exp_rand = exp_rand; v.exp_fail = exp_fail; v.exp_edge = exp_edge;
    return v;
  endfunction

  task automatic set_start(input bit sel, input logic s, input logic [63:0] lim);
    if (sel) begin start_b = s; limit_b = lim; end
    else     begin start_a = s; limit_a = lim; end
  endtask

  task automatic run_op(input bit sel, input string name, input vec_t v, output logic [63:0] got);
    exp_t        e;
    int          k;
    bit          seen;
    logic [63:0] exp_r;
    logic [15:0] w;
    for (int i = 0; i < v.nw; i++) begin
      w = v.words[127 - 16*i -: 16];
      if (sel) wq_b.push_back(w); else wq_a.push_back(w);
    end
    issued.delete();
    @(negedge Clk);
    set_start(sel, 1'b1, v.limit);
    e.rnd = v.exp_rand; e.fail = v.exp_fail; e.edge_n = v.exp_edge;
    sb.push_back(e);
    @(posedge Clk);
    @(negedge Clk);
    set_start(sel, 1'b0, 64'h1);
    k = 0; seen = 1'b0;
    while (!seen && k < 200) begin
      @(posedge Clk); k++; #1;
      if (k == 3) set_start(sel, 1'b1, 64'h1);
      if (k == 4) set_start(sel, 1'b0, 64'h1);
      seen = sel ? done_b : done_a;
    end
    got = sel ? rand_b : rand_a;
    e = sb.pop_front();
    if (!seen) begin
      total++; bad++;
      $display("FAIL %s timeout: no done after %0d edges, expected edge %0d", name, k, e.edge_n);
      set_start(sel, 1'b0, 64'h0);
    end else begin
      exp_r = e.rnd;
      if (v.from_gen) begin
        exp_r = '0;
        for (int i = 0; i < 4; i++) if (issued.size() > 0) exp_r[16*i +: 16] = issued.pop_front();
        exp_r[63] = 1'b1; exp_r[0] = 1'b1;
      end
      check({name, " done edge"}, 64'(k), 64'(e.edge_n));
      check({name, " rand"}, got, exp_r);
      check({name, " fail"}, 64'(sel ? fail_b : fail_a), 64'(e.fail));
      @(posedge Clk); #1;
      check({name, " done one cycle"}, 64'(sel ? done_b : done_a), 64'h0);
      check({name, " idle after"}, 64'(sel ? busy_b : busy_a), 64'h0);
    end
  endtask

  vec_t        vt[6];
  vec_t        vg;
  logic [63:0] got, first;
  int          k;
  bit          seen;

  initial begin
    vt[0] = mk(64'h0, 128'h1111_2222_3333_4444_0000_0000_0000_0000, 4,
               64'hC444_3333_2222_1111, 1'b0, 9);
    vt[1] = mk(64'h8000_0000_0000_0000, 128'h0, 0, 64'hC444_3333_2222_1111, 1'b1, 72);
    vt[2] = mk(64'hF000_0000_0000_0000, 128'h1234_5678_9ABC_F000_0002_0000_0000_1000, 8,
               64'h9000_0000_0000_0003, 1'b0, 18);
    vt[3] = mk(64'h9000_0000_0000_0000, 128'h0000_0000_0000_1000_FFFE_FFFF_FFFF_0FFF, 8,
               64'h8FFF_FFFF_FFFF_FFFF, 1'b0, 18);
    vt[4] = mk(64'h8000_0000_0000_0003, 128'h0003_0000_0000_0000_0001_0000_0000_0000, 8,
               64'h8000_0000_0000_0001, 1'b0, 18);
    vt[5] = mk(64'h1, 128'h0, 0, 64'h8000_0000_0000_0001, 1'b1, 72);

    #12;
    check("reset outputs a", {rand_a[62:0], lst_a, en_a, done_a, fail_a, busy_a}, 64'h0);
    check("reset outputs b", {rand_b[62:0], lst_b, en_b, done_b, fail_b, busy_b}, 64'h0);
    @(negedge Clk); Reset = 1'b1;

    // Enable pattern over edges 0..8 and busy while collecting
    for (int i = 0; i < 4; i++) wq_a.push_back(16'h1111 * 16'(i + 1));
    @(negedge Clk); start_a = 1'b1; limit_a = '0;
    k = 0;
    @(posedge Clk); #1;
    check("enable e0", 64'(en_a), 64'h1);
    start_a = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      @(posedge Clk); #1;
      check($sformatf("enable e%0d", e), 64'(en_a), 64'((e < 8) && (e % 2 == 0)));
      if (e == 8) check("start in check", 64'(lst_a), 64'h1);
    end
    seen = 1'b0;
    while (!seen && k < 20) begin
      @(posedge Clk); k++; #1;
      seen = done_a;
    end
    check("pattern seq done seen", 64'(seen), 64'h1);
    check("pattern seq rand", rand_a, 64'hC444_3333_2222_1111);
    @(posedge Clk); #1;

    foreach (vt[i]) run_op(1'b0, $sformatf("vec%0d", i), vt[i], got);

    run_op(1'b1, "nofrc", mk(64'h4444_3333_2222_1111,
           128'h1111_2222_3333_4444_0001_0000_0000_0000, 8, 64'h1, 1'b0, 18), got);

    // Reset asserted during the third CAP
    wq_a.delete();
    for (int i = 0; i < 4; i++) wq_a.push_back(16'hAAA0 + 16'(i));
    @(negedge Clk); start_a = 1'b1; limit_a = '0;
    @(posedge Clk);
    @(negedge Clk); start_a = 1'b0;
    repeat (5) @(posedge Clk);
    #2 Reset = 1'b0;
    #1 check("midop reset", {rand_a[62:0], lst_a, en_a, done_a, fail_a, busy_a}, 64'h0);
    @(negedge Clk); Reset = 1'b1;
    wq_a.delete();
    run_op(1'b0, "after reset", vt[0], got);

    // Free-running LFSR source, two back-to-back operands
    gen_mode = 1'b1;
    vg = mk(64'h0, 128'h0, 0, 64'h0, 1'b0, 9);
    vg.from_gen = 1'b1;
    run_op(1'b0, "lfsr1", vg, first);
    run_op(1'b0, "lfsr2", vg, got);
    check("lfsr odd msb", {62'h0, got[63], got[0]}, 64'h3);
    total++;
    if (got === first) begin
      bad++;
      $display("FAIL lfsr distinct: got %h twice, expected two different operands", got);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected normal completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rand_operand_builder.md
Name: rand_operand_builder

Overview:
- Sequencer that sits directly downstream of the 16-bit LFSR random generator.
- Drives the generator's Start/Enable inputs and collects NUM_WORDS successive random words into one wide operand, e.g. a prime candidate or a blinding value for the Montgomery exponentiator.
- Optionally forces the MSB and LSB of the operand, and rejects/retries any candidate that is >= a supplied limit (modulus).
- Reports the accepted operand, or failure after MAX_RETRY rejections.

Parameters:
WORD_W, 16, width of one random word from the LFSR generator
NUM_WORDS, 4, words per operand; OP_W = WORD_W*NUM_WORDS (64 by default)
FORCE_MSB, 1, when 1, bit OP_W-1 of the candidate is set before the limit check
FORCE_ODD, 1, when 1, bit 0 of the candidate is set before the limit check
MAX_RETRY, 8, rejected attempts allowed before failure (range 1..255)

Ports:
Clk  in  1  clock, rising edge
Reset  in  1  asynchronous active-low reset
start_i  in  1  request one operand; sampled only in IDLE
limit_i  in  OP_W  unsigned upper bound (exclusive); 0 = no bound; latched at start
lfsr_data_i  in  WORD_W  LFSR_o of the random generator
lfsr_start_o  out  1  to generator Start (advance LFSR)
lfsr_enable_o  out  1  to generator Enable (capture pulse)
rand_o  out  OP_W  last accepted operand
done_o  out  1  one-cycle completion pulse
fail_o  out  1  valid with done_o; 1 = retries exhausted
busy_o  out  1  high in every state except IDLE

Behaviour:
- Reset (async, Reset=0): state IDLE. rand_o, done_o, fail_o, busy_o, lfsr_start_o, lfsr_enable_o, word counter, retry counter and limit register all 0. Reset mid-operation aborts immediately; the partial operand is discarded.
- FSM states: IDLE, REQ, CAP, CHECK, DONE.
- IDLE:
  - start_i=1 at an edge latches limit_i, clears word_cnt and retry_cnt, then moves to REQ.
  - start_i is ignored in every other state; there is no queuing.
- REQ: lfsr_enable_o=1 for exactly one cycle, then CAP.
- CAP:
  - lfsr_enable_o=0. The generator registered its word at the REQ->CAP edge.
  - At the CAP exit edge, lfsr_data_i is written into candidate bits [word_cnt*WORD_W +: WORD_W] (word 0 = LS word).
  - If word_cnt < NUM_WORDS-1: word_cnt increments and the FSM returns to REQ. Otherwise the FSM goes to CHECK.
  - Enable is therefore low for at least one cycle between pulses, which guarantees a fresh rising edge at the generator per word.
- lfsr_start_o = 1 in REQ, CAP and CHECK, so the LFSR free-runs while words are collected. It is 0 in IDLE and DONE.
- CHECK, with forced bits applied (bit OP_W-1 if FORCE_MSB, bit 0 if FORCE_ODD):
  - Accept when limit_reg==0 or candidate < limit_reg (unsigned, full OP_W compare). rand_o <= forced candidate; fail flag 0; go to DONE.
  - Reject otherwise. retry_cnt increments. If the new retry_cnt == MAX_RETRY: set fail flag, leave rand_o unchanged, go to DONE. Else clear word_cnt and go to REQ; the candidate is fully rebuilt.
- DONE: done_o=1 for one cycle; fail_o = fail flag during that cycle, else 0. Unconditional return to IDLE.
- Latency from the start-sampling edge E0, with N=NUM_WORDS:
  - First attempt accepted: done_o high in the cycle after edge 2N+1 (edge 9 by default).
  - Each rejection adds 2N+1 cycles.
- rand_o holds its value until the next accept. It does not change on failure or on a new start.
- limit_i changes after latch have no effect on the current operation.
- With FORCE_MSB=1 and a nonzero limit_reg <= 2^(OP_W-1), every candidate is rejected. This ends in fail after MAX_RETRY attempts, which is intended behaviour.
- Widths: retry_cnt is 8 bits; word_cnt is clog2(NUM_WORDS) bits, minimum 1.

Test Plan:
- Stub generator returns 0x1111,0x2222,0x3333,0x4444 on successive Enable edges; start with limit_i=0 -> done_o at edge 9, rand_o=0xC444_3333_2222_1111, fail_o=0.
- Same stub with FORCE_MSB=0, FORCE_ODD=0, limit_i=0x4444_3333_2222_1111 -> first attempt rejected. Second attempt words 0x0001,0,0,0 -> rand_o=0x1, done_o at edge 18.
- limit_i=0x8000_0000_0000_0000 with defaults -> 8 rejections, done_o with fail_o=1 at edge 72, rand_o keeps its prior value.
- Check lfsr_enable_o pattern: 1,0,1,0,1,0,1,0 over edges 0..8, then 0 in CHECK; start_i pulses while busy_o=1 are ignored.
- Assert Reset low during the third CAP -> all outputs 0 immediately. After release, start yields a clean 9-cycle operation with correct word ordering.
- Real lfsr_random_gen_16 connected, seed 0xACE1, two back-to-back starts -> two different odd operands with MSB set, done_o one cycle each.
